// File: rtl/rc4_keystream_xor_if.sv
// Purpose: handshake bundle between the keystream XOR stage and its neighbours.
// Latency: none, pure wiring.
// Backpressure: carries ks/pt/ct valid-ready pairs; semantics live in the consumer.
interface rc4_keystream_xor_if #(
   parameter int NUMS_OF_BYTES = 4,
   parameter int LEN_W         = 16
);
   logic                       clear;
   logic                       ks_valid;
   logic                       ks_ready;
   logic [NUMS_OF_BYTES*8-1:0] ks_word;
   logic                       pt_valid;
   logic                       pt_ready;
   logic [7:0]                 pt_data;
   logic                       pt_last;
   logic                       ct_valid;
   logic                       ct_ready;
   logic [7:0]                 ct_data;
   logic                       ct_last;
   logic                       busy;
   logic [LEN_W-1:0]           msg_len;

   // Environment side: supplies keystream and plaintext, sinks ciphertext.
   modport master (
      output clear, ks_valid, ks_word, pt_valid, pt_data, pt_last, ct_ready,
      input  ks_ready, pt_ready, ct_valid, ct_data, ct_last, busy, msg_len
   );

   // XOR stage side.
   modport slave (
      input  clear, ks_valid, ks_word, pt_valid, pt_data, pt_last, ct_ready,
      output ks_ready, pt_ready, ct_valid, ct_data, ct_last, busy, msg_len
   );
endinterface

// File: rtl/rc4_keystream_xor.sv
// Purpose: buffers keystream words, unpacks bytes low lane first, XORs with plaintext bytes.
// Latency: 1 cycle from plaintext accept to ct_valid.
// Backpressure: ks_ready = !full; pt_ready needs a keystream word and a free/draining output stage.
module rc4_keystream_xor #(
   parameter int NUMS_OF_BYTES = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int LEN_W         = 16
) (
   input logic                clk,
   input logic                rst,
   rc4_keystream_xor_if.slave bus
);
   localparam int BW    = NUMS_OF_BYTES * 8;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;

   localparam logic [LEN_W-1:0] LEN_MAX  = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUMS_OF_BYTES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_MSG} state_t;

   logic [BW-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic             ct_valid_q, ct_valid_d;
   logic [7:0]       ct_data_q, ct_data_d;
   logic             ct_last_q, ct_last_d;
   state_t           state_q;
   logic             busy_q;
   logic [LEN_W-1:0] len_cnt_q;
   logic [LEN_W-1:0] msg_len_q;

   logic             full, empty, ks_rdy, pt_rdy;
   logic             push, accept, pop;
   logic [BW-1:0]    head_word;
   logic [7:0]       key_byte;
   logic [LEN_W-1:0] len_inc;

   assign full   = (count_q == CNT_FULL);
   assign empty  = (count_q == '0);
   assign ks_rdy = !full;
   assign pt_rdy = !empty && (!ct_valid_q || bus.ct_ready) && !bus.clear;

   // clear wins over a push landing in the same cycle; accept already excludes clear via pt_rdy
   assign push   = bus.ks_valid && ks_rdy && !bus.clear;
   assign accept = bus.pt_valid && pt_rdy;
   assign pop    = accept && (byte_idx_q == IDX_LAST);

   assign head_word = mem_q[rd_ptr_q];
   assign key_byte  = head_word[{byte_idx_q, 3'b000} +: 8];
   assign len_inc   = (len_cnt_q == LEN_MAX) ? LEN_MAX : len_cnt_q + 1'b1;

   assign bus.ks_ready = ks_rdy;
   assign bus.pt_ready = pt_rdy;
   assign bus.ct_valid = ct_valid_q;
   assign bus.ct_data  = ct_data_q;
   assign bus.ct_last  = ct_last_q;
   assign bus.busy     = busy_q;
   assign bus.msg_len  = msg_len_q;

   // Keystream storage; contents are don't-care while the entry is not counted.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.ks_word;
   end

   // Next-state for FIFO pointers, byte lane and the registered output stage.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      ct_valid_d = ct_valid_q;
      ct_data_d  = ct_data_q;
      ct_last_d  = ct_last_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (accept) begin
         byte_idx_d = (byte_idx_q == IDX_LAST) ? '0 : byte_idx_q + 1'b1;
         ct_valid_d = 1'b1;
         ct_data_d  = bus.pt_data ^ key_byte;
         ct_last_d  = bus.pt_last;
      end else if (bus.ct_ready) begin
         ct_valid_d = 1'b0;
      end

      // ct_data/ct_last keep their last value; only the valid is dropped
      if (bus.clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         byte_idx_d = '0;
         ct_valid_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         byte_idx_q <= '0;
         ct_valid_q <= 1'b0;
         ct_data_q  <= '0;
         ct_last_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         ct_valid_q <= ct_valid_d;
         ct_data_q  <= ct_data_d;
         ct_last_q  <= ct_last_d;
      end
   end

   // Message FSM with registered busy and saturating length tracking; msg_len survives clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         len_cnt_q <= '0;
         msg_len_q <= '0;
      end else if (bus.clear) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         len_cnt_q <= '0;
      end else if (accept) begin
         if (bus.pt_last) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            msg_len_q <= len_inc;
            len_cnt_q <= '0;
         end else begin
            state_q   <= S_MSG;
            busy_q    <= 1'b1;
            len_cnt_q <= len_inc;
         end
      end
   end
endmodule

// File: tb/tb_rc4_keystream_xor.sv
// Purpose: directed checks of keystream buffering, XOR, flow control, framing, clear and reset.
// Latency: expects ct one cycle after each plaintext accept.
// Backpressure: exercises full FIFO, empty FIFO and stalled ciphertext output.
module tb_rc4_keystream_xor;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   rc4_keystream_xor_if #(.NUMS_OF_BYTES(4), .LEN_W(16)) bus();

   rc4_keystream_xor #(.NUMS_OF_BYTES(4), .FIFO_DEPTH(4), .LEN_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      int n = 0;
      bus.ks_valid = 1'b1;
      bus.ks_word  = w;
      #1;
      while (!bus.ks_ready && n < 20) begin
         step();
         n++;
      end
      if (!bus.ks_ready) chk("push_timeout", 32'd0, 32'd1);
      step();
      bus.ks_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int n = 0;
      bus.pt_valid = 1'b1;
      bus.pt_data  = d;
      bus.pt_last  = last;
      #1;
      while (!bus.pt_ready && n < 20) begin
         step();
         n++;
      end
      if (!bus.pt_ready) chk("send_timeout", 32'd0, 32'd1);
      step();
      bus.pt_valid = 1'b0;
   endtask

   logic [7:0]  t1_exp [4] = '{8'hD0, 8'hC0, 8'hB0, 8'hA0};
   logic [31:0] t2_w   [4] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
   logic [7:0]  t2_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0]  t5_pt  [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
   logic [7:0]  t5_exp [6] = '{8'h45, 8'h46, 8'h47, 8'hC8, 8'hC9, 8'hCA};

   initial begin
      rst          = 1'b1;
      bus.clear    = 1'b0;
      bus.ks_valid = 1'b0;
      bus.ks_word  = '0;
      bus.pt_valid = 1'b0;
      bus.pt_data  = '0;
      bus.pt_last  = 1'b0;
      bus.ct_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ct_valid", bus.ct_valid, 0);
      chk("rst_ct_data",  bus.ct_data,  0);
      chk("rst_ct_last",  bus.ct_last,  0);
      chk("rst_busy",     bus.busy,     0);
      chk("rst_msg_len",  bus.msg_len,  0);
      chk("rst_ks_ready", bus.ks_ready, 1);
      chk("rst_pt_ready", bus.pt_ready, 0);
      rst = 1'b0;
      step();

      // T1: basic XOR, lane 0 first
      push_word(32'hA3B2C1D0);
      chk("t1_pt_ready", bus.pt_ready, 1);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'(i), i == 3);
         chk("t1_ct_valid", bus.ct_valid, 1);
         chk("t1_ct_data",  bus.ct_data,  t1_exp[i]);
         chk("t1_ct_last",  bus.ct_last,  (i == 3) ? 1 : 0);
         if (i == 0) chk("t1_busy_on", bus.busy, 1);
      end
      chk("t1_empty",    bus.pt_ready, 0);
      chk("t1_busy_off", bus.busy,     0);
      chk("t1_msg_len",  bus.msg_len,  4);
      step();
      chk("t1_ct_drop",  bus.ct_valid, 0);

      // T2: fill FIFO, hold a fifth word until the head pops
      for (int i = 0; i < 4; i++) push_word(t2_w[i]);
      chk("t2_full", bus.ks_ready, 0);
      bus.ks_valid = 1'b1;
      bus.ks_word  = 32'h5A5A5A5A;
      for (int i = 0; i < 4; i++) begin
         send_byte(8'h00, i == 3);
         chk("t2_ct_data", bus.ct_data, t2_exp[i]);
         chk("t2_ks_ready", bus.ks_ready, (i == 3) ? 1 : 0);
      end
      step();
      chk("t2_5th_taken", bus.ks_ready, 0);
      bus.ks_valid = 1'b0;

      // T5: 6-byte message spanning two words, next message continues the keystream
      for (int i = 0; i < 6; i++) begin
         send_byte(t5_pt[i], i == 5);
         chk("t5_ct_data", bus.ct_data, t5_exp[i]);
         chk("t5_ct_last", bus.ct_last, (i == 5) ? 1 : 0);
         if (i == 0) chk("t5_busy_on", bus.busy, 1);
      end
      chk("t5_msg_len",  bus.msg_len, 6);
      chk("t5_busy_off", bus.busy,    0);
      send_byte(8'h00, 1'b0);
      chk("t5_next_lane2", bus.ct_data, 8'hBB);

      // T4: output stall holds data and blocks input
      bus.ct_ready = 1'b0;
      bus.pt_valid = 1'b1;
      bus.pt_data  = 8'h01;
      bus.pt_last  = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("t4_pt_blocked", bus.pt_ready, 0);
         step();
         chk("t4_hold_valid", bus.ct_valid, 1);
         chk("t4_hold_data",  bus.ct_data,  8'hBB);
         chk("t4_hold_last",  bus.ct_last,  0);
      end
      bus.ct_ready = 1'b1;
      #1;
      chk("t4_release", bus.pt_ready, 1);
      step();
      chk("t4_b1", bus.ct_data, 8'hCD);
      bus.pt_data = 8'h02;
      bus.pt_last = 1'b1;
      step();
      bus.pt_valid = 1'b0;
      chk("t4_b2",      bus.ct_data, 8'hDF);
      chk("t4_b2_last", bus.ct_last, 1);
      chk("t4_msg_len", bus.msg_len, 3);

      // T6: clear after two bytes of a word; a push in the clear cycle is dropped
      send_byte(8'h00, 1'b0);
      chk("t6_b0", bus.ct_data, 8'hEE);
      send_byte(8'h00, 1'b0);
      chk("t6_b1", bus.ct_data, 8'hFF);
      chk("t6_busy", bus.busy, 1);
      bus.clear    = 1'b1;
      bus.pt_valid = 1'b1;
      bus.pt_data  = 8'hF0;
      bus.pt_last  = 1'b0;
      bus.ks_valid = 1'b1;
      bus.ks_word  = 32'hEEEEEEEE;
      #1;
      chk("t6_clr_pt_ready", bus.pt_ready, 0);
      step();
      bus.clear    = 1'b0;
      bus.ks_valid = 1'b0;
      chk("t6_ct_valid", bus.ct_valid, 0);
      chk("t6_busy_off", bus.busy,     0);
      chk("t6_msg_len",  bus.msg_len,  3);
      chk("t6_ks_ready", bus.ks_ready, 1);

      // T3: empty FIFO starves plaintext; new word restarts at lane 0
      for (int i = 0; i < 5; i++) begin
         chk("t3_pt_ready", bus.pt_ready, 0);
         step();
         chk("t3_ct_valid", bus.ct_valid, 0);
      end
      bus.ks_valid = 1'b1;
      bus.ks_word  = 32'h0F0E0D0C;
      step();
      bus.ks_valid = 1'b0;
      chk("t3_pt_ready_up", bus.pt_ready, 1);
      step();
      bus.pt_valid = 1'b0;
      chk("t3_ct_valid_up", bus.ct_valid, 1);
      chk("t3_lane0",       bus.ct_data,  8'hFC);
      chk("t3_busy",        bus.busy,     1);

      // T6 with async reset mid-message
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ct_valid", bus.ct_valid, 0);
      chk("arst_ct_data",  bus.ct_data,  0);
      chk("arst_busy",     bus.busy,     0);
      chk("arst_msg_len",  bus.msg_len,  0);
      chk("arst_pt_ready", bus.pt_ready, 0);
      chk("arst_ks_ready", bus.ks_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      bus.pt_valid = 1'b1;
      bus.pt_data  = 8'h55;
      bus.pt_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("arst_no_ct", bus.ct_valid, 0);
      end
      bus.ks_valid = 1'b1;
      bus.ks_word  = 32'h000000AA;
      step();
      bus.ks_valid = 1'b0;
      step();
      bus.pt_valid = 1'b0;
      chk("arst_single_data", bus.ct_data, 8'hFF);
      chk("arst_single_last", bus.ct_last, 1);
      chk("arst_single_busy", bus.busy,    0);
      chk("arst_single_len",  bus.msg_len, 1);
      step();
      chk("arst_ct_drop", bus.ct_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
